// File: rtl/xgmii_link_monitor.sv
// xgmii_link_monitor: RX-side XGMII monitor. Qualifies link-up from PHY health
// and fault ordered sets, counts starts and error columns, and stretches frame
// activity for an LED. Three-stage pipeline: input register, decode, state.
module xgmii_link_monitor #(
  parameter int LINK_QUAL_CYCLES = 1024,
  parameter int FAULT_WINDOW     = 128,
  parameter int ACT_STRETCH      = 1048576,
  parameter int FRAME_CNT_W      = 32,
  parameter int ERR_CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            xgmii_rxd,
  input  logic [7:0]             xgmii_rxc,
  input  logic                   rx_block_lock,
  input  logic                   rx_high_ber,
  input  logic                   cnt_clear,
  output logic                   link_up,
  output logic                   activity_led,
  output logic                   local_fault,
  output logic                   remote_fault,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [ERR_CNT_W-1:0]   error_count
);
  localparam int QW = $clog2(LINK_QUAL_CYCLES + 1);
  localparam int GW = $clog2(FAULT_WINDOW + 1);
  localparam int AW = $clog2(ACT_STRETCH + 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(LINK_QUAL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(FAULT_WINDOW);
  localparam logic [AW-1:0] ACT_LOAD  = AW'(ACT_STRETCH);

  typedef enum logic [1:0] {DOWN, QUAL, UP} state_t;

  // Fault ordered set anchored at a base lane: 0x9C control, then 00 00 code as data.
  function automatic logic fault_set(input logic [31:0] d, input logic [3:0] c,
                                     input logic [7:0] code);
    return (c == 4'b0001) && (d[7:0] == 8'h9C) && (d[15:8] == 8'h00) &&
           (d[23:16] == 8'h00) && (d[31:24] == code);
  endfunction

  logic [63:0] rxd_s1;
  logic [7:0]  rxc_s1;
  logic        lock_s1, ber_s1;
  logic        start0_s2, start4_s2, err_s2, lf_s2, rf_s2, lock_s2, ber_s2;
  logic        err_c;
  logic [1:0]         hit, fault_n;
  logic [1:0][2:0]    seq, seq_n;
  logic [1:0][GW-1:0] gap, gap_n;
  logic        healthy, link_up_n;
  state_t      state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [AW-1:0] act_cnt, act_n;
  logic [FRAME_CNT_W:0] frame_sum;
  logic [ERR_CNT_W:0]   err_sum;

  // Stage 1: register raw XGMII column and PHY status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1 <= '0; rxc_s1 <= '0; lock_s1 <= 1'b0; ber_s1 <= 1'b0;
    end else begin
      rxd_s1 <= xgmii_rxd; rxc_s1 <= xgmii_rxc;
      lock_s1 <= rx_block_lock; ber_s1 <= rx_high_ber;
    end
  end

  // Error character on any control lane flags the whole column.
  always_comb begin
    err_c = 1'b0;
    for (int i = 0; i < 8; i++)
      if (rxc_s1[i] && rxd_s1[8*i +: 8] == 8'hFE) err_c = 1'b1;
  end

  // Stage 2: registered decode flags; a double-anchored fault set counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start0_s2 <= 1'b0; start4_s2 <= 1'b0; err_s2 <= 1'b0;
      lf_s2 <= 1'b0; rf_s2 <= 1'b0; lock_s2 <= 1'b0; ber_s2 <= 1'b0;
    end else begin
      start0_s2 <= rxc_s1[0] && rxd_s1[7:0] == 8'hFB;
      start4_s2 <= rxc_s1[4] && rxd_s1[39:32] == 8'hFB;
      err_s2    <= err_c;
      lf_s2     <= fault_set(rxd_s1[31:0], rxc_s1[3:0], 8'h01) ||
                   fault_set(rxd_s1[63:32], rxc_s1[7:4], 8'h01);
      rf_s2     <= fault_set(rxd_s1[31:0], rxc_s1[3:0], 8'h02) ||
                   fault_set(rxd_s1[63:32], rxc_s1[7:4], 8'h02);
      lock_s2   <= lock_s1;
      ber_s2    <= ber_s1;
    end
  end

  assign hit = {rf_s2, lf_s2};

  // Per-type fault sequencing: index 0 local, 1 remote; opposite type restarts.
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      seq_n[t] = seq[t];
      gap_n[t] = gap[t];
      if (hit[t]) begin
        gap_n[t] = '0;
        if (gap[t] < GAP_MAX) seq_n[t] = (seq[t] == 3'd4) ? 3'd4 : seq[t] + 3'd1;
        else                  seq_n[t] = 3'd1;
      end else begin
        if (gap[t] != GAP_MAX) gap_n[t] = gap[t] + GW'(1);
        if (gap_n[t] == GAP_MAX) seq_n[t] = 3'd0;
      end
      if (hit[1-t]) seq_n[t] = 3'd0;
      fault_n[t] = (seq_n[t] == 3'd4);
    end
  end

  // Health uses next fault state so link drops in the same cycle a fault asserts.
  assign healthy = lock_s2 && !ber_s2 && !fault_n[0] && !fault_n[1];

  // Link FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DOWN; qcnt <= '0;
    end else begin
      state <= state_n; qcnt <= qcnt_n;
    end
  end

  // Link FSM next state; the DOWN->QUAL cycle counts as the first healthy one.
  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    case (state)
      DOWN: if (healthy) begin
        if (LINK_QUAL_CYCLES <= 1) state_n = UP;
        else begin state_n = QUAL; qcnt_n = QW'(1); end
      end
      QUAL: if (!healthy) begin
        state_n = DOWN; qcnt_n = '0;
      end else if (qcnt == QUAL_LAST) begin
        state_n = UP; qcnt_n = '0;
      end else begin
        qcnt_n = qcnt + QW'(1);
      end
      UP: if (!healthy) state_n = DOWN;
      default: begin state_n = DOWN; qcnt_n = '0; end
    endcase
  end

  // Link FSM outputs: link status and activity stretch, both gated by UP.
  always_comb begin
    link_up_n = (state_n == UP);
    act_n     = '0;
    if (state_n == UP) begin
      if (start0_s2 || start4_s2) act_n = ACT_LOAD;
      else if (act_cnt != '0)     act_n = act_cnt - AW'(1);
    end
  end

  assign frame_sum = {1'b0, frame_count} + {{FRAME_CNT_W{1'b0}}, start0_s2}
                                         + {{FRAME_CNT_W{1'b0}}, start4_s2};
  assign err_sum   = {1'b0, error_count} + {{ERR_CNT_W{1'b0}}, err_s2};

  // Stage 3: registered outputs, fault trackers and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= '0; gap <= '0;
      local_fault <= 1'b0; remote_fault <= 1'b0;
      link_up <= 1'b0; act_cnt <= '0; activity_led <= 1'b0;
      frame_count <= '0; error_count <= '0;
    end else begin
      seq <= seq_n; gap <= gap_n;
      local_fault  <= fault_n[0];
      remote_fault <= fault_n[1];
      link_up      <= link_up_n;
      act_cnt      <= act_n;
      activity_led <= (act_n != '0);
      if (cnt_clear) begin
        frame_count <= '0;
        error_count <= '0;
      end else begin
        frame_count <= frame_sum[FRAME_CNT_W] ? '1 : frame_sum[FRAME_CNT_W-1:0];
        error_count <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
      end
    end
  end
endmodule
